dct8_1d_engine: RTL and testbench
=================================

Name: dct8_1d_engine

Overview:
- Parametrised 8-point 1-D DCT/IDCT engine for the image-compression datapath; successor to the floating-point coefficient experiments.
- Uses fixed-point coefficients from a ROM and one multiply-accumulate unit, with valid/ready streaming on both sides.
- Two instances plus a transpose buffer form the 8x8 2-D DCT; this block is the row/column stage.

Parameters:
- IN_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width.
- COEF_FRAC, 14, fractional bits of each coefficient.
- OUT_W, 20, signed output width after rounding and saturation.
- ACC_W, IN_W+COEF_W+3, accumulator width; 8 products cannot overflow it.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_W  signed sample x[n].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  engine accepts a sample this cycle.
- mode  in  1  0 = forward DCT, 1 = inverse; sampled only with sample n=0 of each block.
- out_data  out  OUT_W  signed result y[k].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the result.
- out_last  out  1  high with k=7.

Behaviour:
- Reset: state LOAD, sample count 0, k 0, accumulator 0, in_ready=1, out_valid=0, out_last=0, out_data=0. The mode register is cleared to 0.
- Any partial block is discarded on reset, including mid-MAC or mid-EMIT.
- Coefficients, forward: C[k][n] = round(c(k)*cos((2n+1)k*pi/16)*2^COEF_FRAC).
  - c(0)=sqrt(1/8); c(k>0)=1/2.
  - Each coefficient is rounded in magnitude (half away from zero), then the sign is applied. This makes the symmetric rows sum exactly to 0.
  - At default width: C[0][n]=5793; C[1][0]=8035; C[1][7]=-8035.
- Inverse mode uses the transpose, C[n][k].
- State LOAD:
  - in_ready=1. Each in_valid&in_ready handshake stores the sample into x[cnt] and increments cnt.
  - On the 8th handshake: go to MAC with k=0, acc=0.
  - in_ready=0 in every other state.
- State MAC:
  - 8 cycles, n=0..7: acc += x[n]*coef(k,n), with the product sign-extended to ACC_W.
  - After the 8th cycle: go to EMIT.
- State EMIT:
  - out_data = sat_OUT_W((acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC), using an arithmetic shift and clamping to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_valid=1 and out_last=(k==7). These are held stable until out_ready.
  - On handshake: if k<7, increment k, clear acc, go to MAC. If k==7, go to LOAD with cnt=0, so in_ready=1 on the next cycle.
- Timing:
  - First out_valid comes 9 clocks after the edge that accepts the 8th sample.
  - Output spacing is 9 clocks when out_ready is held high.
  - Backpressure stalls only the EMIT state; the accumulator and k hold their values.
- Output order: k=0..7. Samples presented while in_ready=0 are ignored, not lost from the upstream's view (valid/ready rule: upstream must hold them).
- mode: sampled with the n=0 handshake and held for the whole block. Changes to mode mid-block have no effect.

Decomposition:
- Package dct_pkg holds:
  - default widths;
  - the function that generates the coefficient table (cos evaluation at elaboration, as real values, converted to integers);
  - the state enum LOAD/MAC/EMIT.
- Sub-module dct_coef_rom: combinational 8x8 table indexed by (row, col), with the transpose selected by mode. Parameters COEF_W and COEF_FRAC.

Test Plan:
- Reset, then idle: in_ready=1, out_valid=0, out_data=0. Assert rst during MAC of a block → next block output starts from a fresh LOAD.
- Forward DC input, x[n]=100 for all n → y0=283, y1..y7=0 exactly, out_last on y7; first out_valid exactly 9 clocks after the 8th accept.
- Forward impulse, x0=1000, others 0 → y0=354, y1=490, and y4=354. Check y4's sign and each y_k = round(1000*C[k][0]/16384).
- Round trip: forward DCT of a random block fed into a second instance with mode=1 → reconstructs within ±1 LSB. A mode toggle mid-block has no effect.
- Backpressure: out_ready low for 5 cycles at k=3 → out_data and out_valid held stable, no output dropped or duplicated, in_ready stays 0 until the k=7 handshake.
- Saturation: x[n]=32767 for all n with OUT_W=16 → y0 clamps to 32767. With x[n]=-32768 for all n → y0 clamps to -32768.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point DCT/IDCT engine.
// Provides default datapath widths, the controller state encoding and the
// elaboration-time generator for the fixed-point DCT-II basis table.
package dct_pkg;

  localparam int unsigned IN_W_D      = 16;
  localparam int unsigned COEF_W_D    = 16;
  localparam int unsigned COEF_FRAC_D = 14;
  localparam int unsigned OUT_W_D     = 20;

  localparam real PI_R = 3.14159265358979323846;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_e;

  // C[k][n] = c(k)*cos((2n+1)k*pi/16) scaled by 2^frac. The magnitude is
  // rounded half away from zero before the sign is applied, so mirrored
  // entries of each odd/even row cancel exactly.
  function automatic int dct_coef(input int k, input int n, input int frac);
    real ang;
    real amp;
    real val;
    real mag;
    int  imag;
    ang  = PI_R * real'((2 * n + 1) * k) / 16.0;
    amp  = (k == 0) ? $sqrt(0.125) : 0.5;
    val  = amp * $cos(ang) * real'(1 << frac);
    mag  = (val < 0.0) ? -val : val;
    imag = $rtoi(mag + 0.5);
    return (val < 0.0) ? -imag : imag;
  endfunction

endpackage

// File: rtl/dct_coef_rom.sv
// Combinational 8x8 DCT coefficient table.
// Ports:
//   i_k      - output frequency index k
//   i_n      - sample index n
//   i_mode   - 0: forward, returns C[k][n]; 1: inverse, returns C[n][k]
//   o_coef_c - signed coefficient, COEF_FRAC fractional bits
module dct_coef_rom
  import dct_pkg::*;
#(
  parameter int unsigned COEF_W    = COEF_W_D,
  parameter int unsigned COEF_FRAC = COEF_FRAC_D
) (
  input  logic [2:0]        i_k,
  input  logic [2:0]        i_n,
  input  logic              i_mode,
  output logic [COEF_W-1:0] o_coef_c
);

  logic [COEF_W-1:0] w_tab [64];
  logic [2:0]        w_row;
  logic [2:0]        w_col;

  // Table contents are fixed at elaboration from the real-valued generator.
  for (genvar gr = 0; gr < 8; gr++) begin : g_row
    for (genvar gc = 0; gc < 8; gc++) begin : g_col
      localparam int CV = dct_coef(gr, gc, int'(COEF_FRAC));
      assign w_tab[gr*8+gc] = COEF_W'(CV);
    end
  end

  // Inverse transform reads the transposed matrix.
  assign w_row    = i_mode ? i_n : i_k;
  assign w_col    = i_mode ? i_k : i_n;
  assign o_coef_c = w_tab[{w_row, w_col}];

endmodule

// File: rtl/dct8_1d_engine.sv
// 8-point 1-D DCT/IDCT row/column engine with one shared MAC.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready    - sample stream x[0..7]
//   mode                - 0 forward, 1 inverse; captured with sample 0
//   out_data/out_valid/out_ready - result stream y[0..7]
//   out_last            - marks y[7]
module dct8_1d_engine
  import dct_pkg::*;
#(
  parameter int unsigned IN_W      = IN_W_D,
  parameter int unsigned COEF_W    = COEF_W_D,
  parameter int unsigned COEF_FRAC = COEF_FRAC_D,
  parameter int unsigned OUT_W     = OUT_W_D,
  parameter int unsigned ACC_W     = IN_W + COEF_W + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int unsigned PROD_W = IN_W + COEF_W;

  localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(64'(1) << (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] OMAX_C  = ACC_W'((64'(1) << (OUT_W - 1)) - 64'(1));
  localparam logic signed [ACC_W-1:0] OMIN_C  = ~OMAX_C;

  state_e                    r_state;
  logic [2:0]                r_cnt;
  logic [2:0]                r_k;
  logic [2:0]                r_n;
  logic                      r_mode;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [IN_W-1:0]    r_x [8];

  logic [COEF_W-1:0]         w_coef;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shr;
  logic signed [ACC_W-1:0]   w_sat;
  logic                      w_in_hs;

  dct_coef_rom #(
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_rom (
    .i_k      (r_k),
    .i_n      (r_n),
    .i_mode   (r_mode),
    .o_coef_c (w_coef)
  );

  assign w_in_hs = in_valid && in_ready;

  // One product per MAC cycle, sign-extended into the accumulator.
  assign w_prod    = r_x[r_n] * signed'(w_coef);
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);

  // Round half up, drop the coefficient fraction, then clamp to OUT_W.
  assign w_rnd = r_acc + ROUND_C;
  assign w_shr = w_rnd >>> COEF_FRAC;

  always_comb begin
    w_sat = w_shr;
    if (w_shr > OMAX_C) begin
      w_sat = OMAX_C;
    end else if (w_shr < OMIN_C) begin
      w_sat = OMIN_C;
    end
  end

  // Sample buffer; contents of a discarded block are simply overwritten.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == LOAD) && w_in_hs) begin
      r_x[r_cnt] <= signed'(in_data);
    end
  end

  // Controller: LOAD 8 samples, then per k run 8 MAC cycles and one EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LOAD;
      r_cnt     <= 3'd0;
      r_k       <= 3'd0;
      r_n       <= 3'd0;
      r_mode    <= 1'b0;
      r_acc     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_in_hs) begin
            if (r_cnt == 3'd0) begin
              r_mode <= mode;
            end
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_state  <= MAC;
              r_k      <= 3'd0;
              r_n      <= 3'd0;
              r_acc    <= '0;
              in_ready <= 1'b0;
            end
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          r_n   <= r_n + 3'd1;
          if (r_n == 3'd7) begin
            r_state <= EMIT;
          end
        end
        EMIT: begin
          // First EMIT cycle registers the result; it then holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_last  <= (r_k == 3'd7);
            out_data  <= OUT_W'(w_sat);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (r_k == 3'd7) begin
              r_state  <= LOAD;
              r_cnt    <= 3'd0;
              in_ready <= 1'b1;
            end else begin
              r_state <= MAC;
              r_k     <= r_k + 3'd1;
              r_n     <= 3'd0;
              r_acc   <= '0;
            end
          end
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dct8_1d_engine.sv
module tb_dct8_1d_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               s_in_ready;
  logic               mode;
  logic signed [19:0] out_data;
  logic signed [15:0] s_out_data;
  logic               out_valid;
  logic               s_out_valid;
  logic               out_ready;
  logic               out_last;
  logic               s_out_last;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  int xs   [8];
  int yi   [8];
  int ys   [8];
  int ysat [8];
  int tv   [8];
  int imp_exp [8] = '{354, 490, 462, 416, 354, 278, 191, 98};
  int t_acc;
  int d;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct8_1d_engine u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Same stimulus, narrow output to exercise saturation.
  dct8_1d_engine #(.OUT_W(16)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .mode      (mode),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_last  (s_out_last)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send_block(input int x[8], input logic m, input bit tog, output int t_done);
    int guard;
    for (int i = 0; i < 8; i++) begin
      in_data  = 16'(x[i]);
      in_valid = 1'b1;
      mode     = (i == 0 || !tog) ? m : ~m;
      guard    = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 200) chk("accept_wait", guard, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    t_done   = cyc;
  endtask

  task automatic recv_block(input int stall_k, output int y[8], output int yn[8], output int t[8]);
    int got;
    int guard;
    bit stalled;
    logic signed [19:0] hold_d;
    got = 0; guard = 0; stalled = 1'b0; out_ready = 1'b1;
    while (got < 8 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      if (out_valid && got == stall_k && !stalled) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        hold_d    = out_data;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); #1;
          chk("bp_valid", out_valid, 1);
          chk("bp_data", out_data, hold_d);
          chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        y[got]  = int'(out_data);
        yn[got] = int'(s_out_data);
        t[got]  = cyc;
        chk($sformatf("last_k%0d", got), out_last, (got == 7) ? 1 : 0);
        chk($sformatf("busy_in_ready_k%0d", got), in_ready, 0);
        got++;
      end
    end
    if (got < 8) chk("recv_count", got, 8);
    @(posedge clk); #1;
    chk("in_ready_reload", in_ready, 1);
    chk("no_extra_valid", out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);

    // Forward DC: only y0 non-zero, latency and spacing.
    for (int i = 0; i < 8; i++) xs[i] = 100;
    send_block(xs, 1'b0, 1'b0, t_acc);
    recv_block(-1, ys, ysat, tv);
    chk("first_valid_latency", tv[0] - t_acc, 9);
    chk("handshake_to_next_valid", tv[1] - (tv[0] + 1), 9);
    chk("dc_y0", ys[0], 283);
    for (int k = 1; k < 8; k++) chk($sformatf("dc_y%0d", k), ys[k], 0);

    // Reset in the middle of MAC discards the block.
    send_block(xs, 1'b0, 1'b0, t_acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("midrst_stale_valid", out_valid, 0);

    // Forward impulse with a mode toggle after sample 0 and backpressure at k=3.
    xs = '{1000, 0, 0, 0, 0, 0, 0, 0};
    send_block(xs, 1'b0, 1'b1, t_acc);
    recv_block(3, ys, ysat, tv);
    for (int k = 0; k < 8; k++) chk($sformatf("imp_y%0d", k), ys[k], imp_exp[k]);
    yi = ys;

    // Inverse of the impulse spectrum reconstructs the impulse within 1 LSB.
    send_block(yi, 1'b1, 1'b1, t_acc);
    recv_block(-1, ys, ysat, tv);
    for (int n = 0; n < 8; n++) begin
      d = ys[n] - xs[n];
      chk($sformatf("roundtrip_err_n%0d", n), (d > 1 || d < -1) ? d : 0, 0);
    end

    // Positive full scale saturates the 16-bit instance.
    for (int i = 0; i < 8; i++) xs[i] = 32767;
    send_block(xs, 1'b0, 1'b0, t_acc);
    recv_block(-1, ys, ysat, tv);
    chk("satpos_narrow_y0", ysat[0], 32767);
    chk("satpos_wide_y0", ys[0], 92685);
    chk("satpos_narrow_y1", ysat[1], 0);

    // Negative full scale.
    for (int i = 0; i < 8; i++) xs[i] = -32768;
    send_block(xs, 1'b0, 1'b0, t_acc);
    recv_block(-1, ys, ysat, tv);
    chk("satneg_narrow_y0", ysat[0], -32768);
    chk("satneg_wide_y0", ys[0], -92688);
    chk("satneg_narrow_y7", ysat[7], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
